// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0]  PS2_BREAK           = 8'hF0;
    localparam logic [7:0]  PS2_EXT             = 8'hE0;
    localparam int unsigned PS2_TIMEOUT_DEFAULT = 50000;
    localparam int unsigned PS2_DATA_BITS       = 8;

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the raw PS/2 lines plus a registered falling-edge strobe.
module ps2_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic dat_s,
    output logic clk_fall
);

    logic clk_meta;
    logic clk_s;
    logic dat_meta;

    // Lines idle high, so reset the chain to 1 to avoid a fake edge after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_s    <= 1'b1;
            dat_meta <= 1'b1;
            dat_s    <= 1'b1;
            clk_fall <= 1'b0;
        end else begin
            clk_meta <= ps2_clk;
            clk_s    <= clk_meta;
            dat_meta <= ps2_dat;
            dat_s    <= dat_meta;
            clk_fall <= clk_s & ~clk_meta;
        end
    end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver: decodes F0/E0 prefixes into make/break and extended flags.
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] keyboard_code,
    output logic       makeBreak,
    output logic       extended,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned BIT_W    = $clog2(PS2_DATA_BITS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PS2_DATA_BITS - 1);

    logic dat_s;
    logic clk_fall;

    ps2_state_e        state_q,  state_n;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_n;
    logic [7:0]        shift_q,  shift_n;
    logic              parity_q, parity_n;
    logic [TMO_W-1:0]  tmo_q,    tmo_n;
    logic              brk_q,    brk_n;
    logic              ext_q,    ext_n;
    logic [7:0]        code_n;
    logic              mb_n;
    logic              extd_n;
    logic              valid_n;
    logic              err_n;

    ps2_sync_edge u_sync (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .dat_s    (dat_s),
        .clk_fall (clk_fall)
    );

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            tmo_q         <= '0;
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            keyboard_code <= 8'h00;
            makeBreak     <= 1'b0;
            extended      <= 1'b0;
            code_valid    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            state_q       <= state_n;
            bit_cnt_q     <= bit_cnt_n;
            shift_q       <= shift_n;
            parity_q      <= parity_n;
            tmo_q         <= tmo_n;
            brk_q         <= brk_n;
            ext_q         <= ext_n;
            keyboard_code <= code_n;
            makeBreak     <= mb_n;
            extended      <= extd_n;
            code_valid    <= valid_n;
            frame_err     <= err_n;
        end
    end

    // Frame FSM; a PS/2 edge always takes precedence over the timeout.
    always_comb begin
        state_n   = state_q;
        bit_cnt_n = bit_cnt_q;
        shift_n   = shift_q;
        parity_n  = parity_q;
        tmo_n     = tmo_q;
        brk_n     = brk_q;
        ext_n     = ext_q;
        code_n    = keyboard_code;
        mb_n      = makeBreak;
        extd_n    = extended;
        valid_n   = 1'b0;
        err_n     = 1'b0;

        if (clk_fall) begin
            tmo_n = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_n[bit_cnt_q] = dat_s;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_n = ST_PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt_q + BIT_W'(1);
                    end
                end
                ST_PARITY: begin
                    parity_n = dat_s;
                    state_n  = ST_STOP;
                end
                ST_STOP: begin
                    state_n = ST_IDLE;
                    if (dat_s && ((^shift_q) ^ parity_q)) begin
                        if (shift_q == PS2_BREAK) begin
                            brk_n = 1'b1;
                        end else if (shift_q == PS2_EXT) begin
                            ext_n = 1'b1;
                        end else begin
                            code_n  = shift_q;
                            mb_n    = ~brk_q;
                            extd_n  = ext_q;
                            valid_n = 1'b1;
                            brk_n   = 1'b0;
                            ext_n   = 1'b0;
                        end
                    end else begin
                        err_n = 1'b1;
                        brk_n = 1'b0;
                        ext_n = 1'b0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_n = ST_IDLE;
                tmo_n   = '0;
                err_n   = 1'b1;
                brk_n   = 1'b0;
                ext_n   = 1'b0;
            end else begin
                tmo_n = tmo_q + TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed plus randomized PS/2 frames checked against a byte-level decoding model.
module tb_ps2_scancode_receiver;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] keyboard_code;
    logic       makeBreak;
    logic       extended;
    logic       code_valid;
    logic       frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_both   = 0;
    int last_valid_cyc = 0;
    int last_err_cyc   = 0;
    int last_fall_cyc  = 0;

    // Reference model state: what a keyboard host should have decoded so far.
    logic [7:0] m_code  = 8'h00;
    bit         m_mb    = 1'b0;
    bit         m_ext   = 1'b0;
    bit         m_brk   = 1'b0;
    bit         m_epend = 1'b0;

    ps2_scancode_receiver #(.TIMEOUT_CYCLES(100)) dut (
        .clock         (clock),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_dat       (ps2_dat),
        .keyboard_code (keyboard_code),
        .makeBreak     (makeBreak),
        .extended      (extended),
        .code_valid    (code_valid),
        .frame_err     (frame_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (code_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
        end
        if (frame_err) begin
            n_err        <= n_err + 1;
            last_err_cyc <= cyc;
        end
        if (code_valid && frame_err) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Byte-level decoding rules: prefixes only arm flags, bad frames drop them.
    task automatic model_frame(input logic [7:0] b, input bit good, output int ev, output int ee);
        ev = 0;
        ee = 0;
        if (!good) begin
            ee      = 1;
            m_brk   = 1'b0;
            m_epend = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_epend = 1'b1;
        end else begin
            m_code  = b;
            m_mb    = !m_brk;
            m_ext   = m_epend;
            m_brk   = 1'b0;
            m_epend = 1'b0;
            ev      = 1;
        end
    endtask

    // Drive the first n_falls bits of a frame, one PS/2 clock period per bit.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int n_falls);
        logic [10:0] bits;
        logic        par;
        par  = (~^b) ^ bad_par;
        bits = {1'b1, par, b, 1'b0};
        for (int i = 0; i < n_falls; i++) begin
            @(negedge clock) ps2_dat = bits[i];
            repeat (4) @(negedge clock);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (8) @(negedge clock);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clock);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_code"}, 32'(keyboard_code), 32'(m_code));
        chk({tag, "_mb"},   32'(makeBreak),     32'(m_mb));
        chk({tag, "_ext"},  32'(extended),      32'(m_ext));
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input bit bad_par);
        int v0, e0, ev, ee;
        v0 = n_valid;
        e0 = n_err;
        send_frame(b, bad_par, 11);
        repeat (20) @(negedge clock);
        model_frame(b, !bad_par, ev, ee);
        chk({tag, "_valid_cnt"}, n_valid - v0, ev);
        chk({tag, "_err_cnt"},   n_err - e0,   ee);
        chk_outputs(tag);
    endtask

    initial begin
        int v0, e0;
        logic [7:0] rb;
        bit bad;

        // Reset state
        repeat (5) @(negedge clock);
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_err",   32'(frame_err),  32'd0);
        chk_outputs("rst");
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Plain make code and pipeline latency from the raw stop-bit edge
        do_frame("make_1c", 8'h1C, 1'b0);
        chk("latency", last_valid_cyc - last_fall_cyc, 3);

        // Break sequence; the prefix alone must not pulse
        v0 = n_valid;
        do_frame("pre_f0", 8'hF0, 1'b0);
        do_frame("brk_1c", 8'h1C, 1'b0);
        chk("brk_seq_one_pulse", n_valid - v0, 1);

        // Extended break, then a plain make clears both flags
        do_frame("pre_e0", 8'hE0, 1'b0);
        do_frame("pre_f0b", 8'hF0, 1'b0);
        do_frame("ext_brk_5a", 8'h5A, 1'b0);
        do_frame("make_29", 8'h29, 1'b0);

        // Parity error, then a normal break
        do_frame("bad_par_15", 8'h15, 1'b1);
        do_frame("pre_f0c", 8'hF0, 1'b0);
        do_frame("brk_15", 8'h15, 1'b0);

        // Timeout after 4 data bits; a pending break must be dropped
        do_frame("pre_f0d", 8'hF0, 1'b0);
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h6B, 1'b0, 5);
        repeat (120) @(negedge clock);
        chk("tmo_err_cnt",   n_err - e0,   1);
        chk("tmo_valid_cnt", n_valid - v0, 0);
        chk("tmo_latency",   last_err_cyc - last_fall_cyc, 103);
        m_brk   = 1'b0;
        m_epend = 1'b0;
        chk_outputs("tmo_hold");
        do_frame("after_tmo_23", 8'h23, 1'b0);

        // Randomized byte stream, biased toward prefixes, with occasional parity errors
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    rb = 8'hF0;
                2:       rb = 8'hE0;
                default: rb = 8'($urandom);
            endcase
            bad = ($urandom_range(0, 7) == 0);
            do_frame("rand", rb, bad);
        end

        // Reset while waiting for the parity bit, with a break prefix armed
        do_frame("pre_f0e", 8'hF0, 1'b0);
        v0 = n_valid;
        e0 = n_err;
        send_frame(8'h2B, 1'b0, 9);
        @(negedge clock) reset = 1'b1;
        repeat (2) @(negedge clock);
        m_code  = 8'h00;
        m_mb    = 1'b0;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_epend = 1'b0;
        chk_outputs("mid_rst");
        reset = 1'b0;
        repeat (20) @(negedge clock);
        chk("mid_rst_valid_cnt", n_valid - v0, 0);
        chk("mid_rst_err_cnt",   n_err - e0,   0);
        chk_outputs("post_rst");
        do_frame("after_rst_2b", 8'h2B, 1'b0);

        chk("no_overlap", n_both, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
